// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin APB master with bounded pready timeout.
module apb_arbiter_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [1:0]  req,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [1:0]        done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Next-state, arbitration, transfer capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    done_d    = 2'b00;

    case (state_q)
      IDLE: begin
        if (|req) begin
          // Contention goes to the requester that did not win last time.
          win_d    = (req == 2'b11) ? ~last_q : req[1];
          pwrite_d = win_d ? req_write[1]     : req_write[0];
          paddr_d  = win_d ? req_addr[63:32]  : req_addr[31:0];
          pwdata_d = win_d ? req_wdata[63:32] : req_wdata[31:0];
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          err_d   = pslverr;
          rdata_d = pwrite_q ? 32'h0 : prdata;
          state_d = COMPLETE;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      COMPLETE: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    if (state_d == COMPLETE) begin
      done_d = win_q ? 2'b10 : 2'b01;
    end
  end

  // State and output registers; reset drops any in-flight transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      done_q    <= 2'b00;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: doc/apb_arbiter_master.md
# apb_arbiter_master

Two-requester APB master that shares a single APB slave (the `apb_ram` 32-word memory) between two internal requesters. It arbitrates round-robin, drives the APB SETUP/ACCESS sequence, and waits for `pready`, with a bounded timeout. It returns read data and the error status to the winning requester as a one-cycle `done` pulse. It sits between the requester logic and the slave's `psel/penable/pwrite/paddr/pwdata` inputs.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum ACCESS cycles to wait for `pready` before forcing an error completion. Range 1..255; an 8-bit counter.

Ports:
- `pclk`  in  1  clock; all state changes on the rising edge.
- `presetn`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester transfer request; held high until the matching `done`.
- `req_write`  in  2  1 = write, 0 = read; stable while `req[i]` is high.
- `req_addr`  in  64  requester i address at bits [32i+31:32i].
- `req_wdata`  in  64  requester i write data at bits [32i+31:32i].
- `done`  out  2  one-cycle completion pulse to requester i.
- `rdata`  out  32  read data; valid while `done` is high.
- `err`  out  1  error flag; valid while `done` is high (`pslverr` or timeout).
- `psel`, `penable`, `pwrite`  out  1 each  APB controls.
- `paddr`, `pwdata`  out  32 each  APB address and write data.
- `prdata`  in  32  slave read data.
- `pready`, `pslverr`  in  1 each  slave ready and error.

## Operation
- FSM states:
  - IDLE: `psel=0`, `penable=0`.
    - If any `req` is high, pick the winner, latch its write/address/data into `pwrite/paddr/pwdata`, and go to SETUP.
    - If no `req` is high, stay in IDLE.
  - SETUP: `psel=1`, `penable=0`, one cycle; always go to ACCESS. Clear the timeout counter.
  - ACCESS: `psel=1`, `penable=1`.
    - If `pready=1`: capture `pslverr` into `err`; for reads, capture `prdata` into `rdata`; go to COMPLETE.
    - Else if the counter equals TIMEOUT-1: set `err=1` and `rdata=0`; go to COMPLETE.
    - Else increment the counter.
  - COMPLETE: `psel=0`, `penable=0`, `done[winner]=1`; go to IDLE.
- Arbitration is round-robin on a `last` pointer.
  - When only one requester is active, it wins.
  - When both are active, the requester other than `last` wins.
  - `last` updates to the winner in COMPLETE.
  - After reset `last=1`, so requester 0 wins the first contention.
- `paddr/pwdata/pwrite` stay stable from SETUP through ACCESS and are not re-sampled mid-transfer.
- Writes leave `rdata` at 0 in their `done` cycle.
- Requester protocol: deassert `req[i]` in the cycle after `done[i]`, or keep it high to request another transfer. Changing `req_*` while `req[i]` is high and not yet done is illegal.
- Out-of-range addresses (the slave uses ≥32) are passed through unchanged. The error is reported via `pslverr` → `err=1`.
- All outputs are registered.

## Timing
- Reset values: `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `done=2'b00`, `rdata=0`, `err=0`. State = IDLE, `last=1`, counter = 0.
- Reset asserted mid-transfer clears everything immediately, asynchronously. The in-flight transfer is dropped with no `done`, and the requester must reissue it.
- With `req` seen high at edge N in IDLE and `pready=1` on first ACCESS:
  - SETUP at N+1.
  - ACCESS at N+2.
  - COMPLETE/`done` at N+3.
  - IDLE at N+4.
  - Minimum 4 cycles per transfer.
- Each ACCESS cycle without `pready` adds one cycle.
- Timeout `done` occurs TIMEOUT cycles after entering ACCESS.
- Back-to-back: the next SETUP can begin at N+5. With both requesters continuously active, grants alternate 0,1,0,1.
- If `pready` and the timeout hit in the same cycle, `pready` wins: normal completion, `err = pslverr`.

## Test plan
- Reset then single write, req0 addr=5 wdata=0xDEADBEEF, `pready` high in ACCESS → APB SETUP then ACCESS with `paddr=5`, `pwrite=1`; `done[0]` pulses 3 cycles after the req edge with `err=0`.
- Read back, req1 addr=5 read, slave returns 0xDEADBEEF → `done[1]` pulse, `rdata=0xDEADBEEF`, `err=0`.
- Both req held continuously (reads to addr 1 and 2) → grant order 0,1,0,1; every `done` pulse lasts exactly one cycle; `paddr` alternates 1,2.
- Out-of-range read, addr=40, slave `pslverr=1` → `done` with `err=1`, APB returns to `psel=0` the next cycle.
- `pready` held low with TIMEOUT=4 → `done` 4 cycles after ACCESS entry, `err=1`, `rdata=0`.
- `presetn` pulsed low during ACCESS → all outputs 0 immediately, no `done`; a subsequent request completes normally.
